// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter (dmem_arbiter).
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef logic port_t;

  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for dmem_arbiter.
// DMEM_ARB_ROUND_ROBIN_EN: ties go to the port that did not win last; otherwise port 0 wins ties.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic  req0,
  input  logic  req1,
  input  port_t last_win,
  output port_t win
);

`ifndef DMEM_ARB_ROUND_ROBIN_EN
  logic unused_last_win;
  assign unused_last_win = last_win;
`endif

  // Winner select; with no request the result is ignored by the caller
  always_comb begin
    win = PORT0;
    if (req1 && !req0) begin
      win = PORT1;
    end else if (req0 && req1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      win = (last_win == PORT0) ? PORT1 : PORT0;
`else
      win = PORT0;
`endif
    end else begin
      win = PORT0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory (IDLE -> ACCESS -> DONE).
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default build is fixed priority (port 0).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_RD
);

  arb_state_t        state;
  arb_state_t        state_nxt;
  port_t             win;
  port_t             last_win;
  port_t             sel;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              any_req;
  logic              start;
  logic              finish;

  assign any_req = req0 | req1;
  assign start   = (state == IDLE) && any_req;
  assign finish  = (state == ACCESS);

  dmem_arb_pick u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_win (last_win),
    .win      (win)
  );

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Last-winner pointer, moved on every entry to ACCESS
  always_ff @(posedge clk) begin
    if (rst) begin
      last_win <= PORT1;
    end else if (start) begin
      last_win <= win;
    end
  end
`else
  assign last_win = PORT1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; requests seen in DONE are ignored
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture from the winning port
  always_ff @(posedge clk) begin
    if (rst) begin
      sel     <= PORT0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (start) begin
      sel     <= win;
      we_q    <= (win == PORT1) ? we1    : we0;
      addr_q  <= (win == PORT1) ? addr1  : addr0;
      wdata_q <= (win == PORT1) ? wdata1 : wdata0;
    end
  end

  // Completion pulses and read-data capture at the edge ending ACCESS
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      gnt0    <= finish && (sel == PORT0);
      gnt1    <= finish && (sel == PORT1);
      rvalid0 <= finish && (sel == PORT0) && !we_q;
      rvalid1 <= finish && (sel == PORT1) && !we_q;
      if (finish && !we_q && (sel == PORT0)) begin
        rdata0 <= mem_RD;
      end
      if (finish && !we_q && (sel == PORT1)) begin
        rdata1 <= mem_RD;
      end
    end
  end

  // Address/data hold the last latched command; the write strobe is cut by reset
  assign mem_A  = addr_q;
  assign mem_WD = wdata_q;
  assign mem_WE = (state == ACCESS) && we_q && !rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus randomized two-port traffic
// against a transaction-level memory model.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE;
  logic        mem_init;

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] last_rd [2];
  cmd_t        q0[$];
  cmd_t        q1[$];
  int          we_cnt;
  logic [31:0] we_a, we_d;
  int          n_cmp = 0;
  int          n_bad = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  // Behavioural single-port memory: combinational read, 0 while writing
  assign mem_RD = mem_WE ? 32'd0 : mem[mem_A[3:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else if (mem_WE) begin
      mem[mem_A[3:0]] <= mem_WD;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Pop the expected command for port p and check the response against the model
  task automatic svc(input int p, input logic rv, input logic [31:0] rd);
    cmd_t c;
    logic have;
    have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
    chk("gnt_has_cmd", 64'(have), 64'd1);
    if (have) begin
      if (p == 0) c = q0.pop_front();
      else        c = q1.pop_front();
      chk("rvalid_kind", 64'(rv), 64'(!c.we));
      if (c.we) begin
        chk("we_pulses", 64'(we_cnt), 64'd1);
        chk("we_addr", 64'(we_a), 64'(c.addr));
        chk("we_data", 64'(we_d), 64'(c.wdata));
        chk("rdata_hold", 64'(rd), 64'(last_rd[p]));
        ref_mem[c.addr[3:0]] = c.wdata;
      end else begin
        chk("we_pulses_rd", 64'(we_cnt), 64'd0);
        chk("rdata", 64'(rd), 64'(ref_mem[c.addr[3:0]]));
        last_rd[p] = ref_mem[c.addr[3:0]];
      end
    end
  endtask

  // Monitor: samples on the falling edge, decoupled from stimulus
  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    we_cnt = 0;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        we_cnt = 0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
      end else begin
        if (mem_WE) begin
          we_cnt++;
          we_a = mem_A;
          we_d = mem_WD;
        end
        if (gnt0 | gnt1 | rvalid0 | rvalid1) begin
          chk("one_port_only", 64'({gnt0 & gnt1, rvalid0 & rvalid1}), 64'd0);
          chk("rvalid_needs_gnt", 64'({rvalid0 & !gnt0, rvalid1 & !gnt1}), 64'd0);
        end
        if (gnt0) svc(0, rvalid0, rdata0);
        if (gnt1) svc(1, rvalid1, rdata1);
        if (gnt0 | gnt1) we_cnt = 0;
      end
    end
  end

  task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_t c;
    c.we = w; c.addr = a; c.wdata = d;
    if (p == 0) begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; q0.push_back(c);
    end else begin
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; q1.push_back(c);
    end
  endtask

  // Wait for every raised request to be granted; drop each on its gnt
  task automatic drain(input int max_cyc, output int g0, output int g1);
    int n;
    n = 0; g0 = -1; g1 = -1;
    while ((req0 || req1) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
      if (gnt0 && req0) begin g0 = n; req0 = 1'b0; end
      if (gnt1 && req1) begin g1 = n; req1 = 1'b0; end
    end
    chk("drain_complete", 64'({req0, req1}), 64'd0);
    if (req0 || req1) begin
      req0 = 1'b0; req1 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      q0.delete(); q1.delete();
    end
  endtask

  task automatic run(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                     output int lat);
    int g0, g1;
    @(posedge clk); #1;
    issue(p, w, a, d);
    drain(20, g0, g1);
    lat = (p == 0) ? g0 : g1;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int lat, g0, g1, w0, w1, max_wait;
    logic e0, e1;
    rst = 1'b1; mem_init = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd9; wdata0 = 32'd0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;

    // Reset held two cycles with req0 high
    @(posedge clk); #1 mem_init = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ctrl", 64'({gnt0, gnt1, rvalid0, rvalid1, mem_WE}), 64'd0);
      chk("rst_rdata", {rdata0, rdata1}, 64'd0);
      chk("rst_mem_bus", {mem_A, mem_WD}, 64'd0);
      if (gnt0 | gnt1) q0.delete();
    end
    @(posedge clk); #1;
    req0 = 1'b0; rst = 1'b0;

    // Port-0 write then read back
    run(0, 1'b1, 32'd5, 32'hDEADBEEF, lat);
    chk("wr_latency", 64'(lat), 64'd2);
    run(0, 1'b0, 32'd5, 32'd0, lat);
    chk("rd_latency", 64'(lat), 64'd2);
    chk("rd_back", 64'(rdata0), 64'h0000_0000_DEAD_BEEF);

    // Simultaneous reads after reset: port 0 first, port 1 three cycles later
    reset_dut();
    @(posedge clk); #1;
    issue(0, 1'b0, 32'd1, 32'd0);
    issue(1, 1'b0, 32'd2, 32'd0);
    drain(20, g0, g1);
    chk("tie_gnt0_cycle", 64'(g0), 64'd2);
    chk("tie_gnt1_cycle", 64'(g1), 64'd5);
    chk("tie_rdata1", 64'(rdata1), 64'(init_val(2)));

    // Reset during the ACCESS cycle of a write
    @(posedge clk); #1;
    issue(0, 1'b1, 32'd7, 32'h12345678);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rma_we_gated", 64'(mem_WE), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; req0 = 1'b0; q0.delete();
    repeat (4) begin
      @(negedge clk);
      chk("rma_no_gnt", 64'({gnt0, gnt1, mem_WE}), 64'd0);
    end
    chk("rma_mem7", 64'(mem[7]), 64'(init_val(7)));
    run(0, 1'b0, 32'd7, 32'd0, lat);
    chk("rma_idle_latency", 64'(lat), 64'd2);
    chk("rma_rdata", 64'(rdata0), 64'(init_val(7)));

    // rdata hold across a write on the same port
    run(1, 1'b1, 32'd3, 32'hA5A5A5A5, lat);
    run(1, 1'b0, 32'd3, 32'd0, lat);
    chk("hold_rd", 64'(rdata1), 64'h0000_0000_A5A5_A5A5);
    run(1, 1'b1, 32'd4, 32'h0BADF00D, lat);
    chk("hold_after_wr", 64'(rdata1), 64'h0000_0000_A5A5_A5A5);

    // Both ports saturated
    reset_dut();
    @(posedge clk); #1;
    issue(0, 1'b0, 32'd1, 32'd0);
    issue(1, 1'b0, 32'd2, 32'd0);
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      e0 = 1'b0; e1 = 1'b0;
      if (c >= 2 && (c - 2) % 3 == 0) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        if (((c - 2) / 3) % 2 == 0) e0 = 1'b1;
        else                        e1 = 1'b1;
`else
        e0 = 1'b1;
`endif
      end
      chk("sat_gnt", 64'({gnt1, gnt0}), 64'({e1, e0}));
      if (gnt0) issue(0, 1'b0, 32'd1, 32'd0);
      if (gnt1) issue(1, 1'b0, 32'd2, 32'd0);
    end
    drain(30, g0, g1);

    // Randomized two-port traffic
    reset_dut();
    w0 = 0; w1 = 0; max_wait = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (req0 && gnt0) begin
        req0 = 1'b0; w0 = 0;
      end else if (!req0 && $urandom_range(1, 0) == 1) begin
        issue(0, 1'($urandom_range(1, 0)), 32'($urandom_range(15, 0)), $urandom);
      end
      if (req1 && gnt1) begin
        req1 = 1'b0; w1 = 0;
      end else if (!req1 && $urandom_range(1, 0) == 1) begin
        issue(1, 1'($urandom_range(1, 0)), 32'($urandom_range(15, 0)), $urandom);
      end
      if (req0) w0++;
      if (req1) w1++;
      if (w0 > max_wait) max_wait = w0;
      if (w1 > max_wait) max_wait = w1;
    end
    chk("rand_wait_bounded", 64'(max_wait <= 60), 64'd1);
    drain(80, g0, g1);
    repeat (3) @(posedge clk);
    #1;
    chk("queues_empty", 64'(q0.size() + q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
